// File: rtl/sd_cmd_arbiter.sv
// Fixed-priority arbiter (CMD12 > CMD23 > driver) sequencing one SD command at a time through issue, response wait and Ncc gap.
// Grant is combinational in IDLE; result/watchdog pulses are registered one cycle after the completing event.
module sd_cmd_arbiter #(
    parameter int GapCycles      = 8,
    parameter int WatchdogCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_p_i,
    input  logic [2:0]  req_valid_i,
    input  logic [17:0] req_cmd_i,
    input  logic [95:0] req_arg_i,
    input  logic [5:0]  req_rsp_type_i,
    output logic [2:0]  req_ready_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [5:0]  cmd_o,
    output logic [31:0] cmd_arg_o,
    output logic [1:0]  rsp_type_o,
    input  logic        cmd_done_i,
    input  logic        cmd_result_valid_i,
    input  logic        cmd_error_i,
    input  logic        timeout_i,
    output logic [2:0]  result_valid_o,
    output logic        result_error_o,
    output logic        wd_timeout_o,
    output logic        err_locked_o,
    input  logic        clear_err_i,
    output logic        busy_o,
    output logic [1:0]  owner_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int GW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;
    localparam int WW = (WatchdogCycles > 0) ? $clog2(WatchdogCycles + 1) : 1;
    localparam logic [WW:0] WD_LIMIT = (WW+1)'(WatchdogCycles);

    logic [1:0]    state;
    logic [GW-1:0] gap_cnt;
    logic [WW-1:0] wd_cnt;

    logic [2:0]  grant_oh;
    logic [1:0]  grant_idx;
    logic        grant;
    logic [5:0]  sel_cmd;
    logic [31:0] sel_arg;
    logic [1:0]  sel_rsp;
    logic [2:0]  owner_oh;

    logic        active;
    logic [WW:0] wd_inc;
    logic        wd_expire;
    logic        rsp_done;
    logic        complete;
    logic        cpl_err;
    logic        err_event;

    always_comb begin
        grant_oh  = 3'b000;
        grant_idx = 2'd3;
        if (state == S_IDLE && !err_locked_o) begin
            if (req_valid_i[0]) begin
                grant_oh  = 3'b001;
                grant_idx = 2'd0;
            end else if (req_valid_i[1]) begin
                grant_oh  = 3'b010;
                grant_idx = 2'd1;
            end else if (req_valid_i[2]) begin
                grant_oh  = 3'b100;
                grant_idx = 2'd2;
            end
        end
    end

    assign grant       = |grant_oh;
    assign req_ready_o = grant_oh;

    always_comb begin
        sel_cmd = req_cmd_i[5:0];
        sel_arg = req_arg_i[31:0];
        sel_rsp = req_rsp_type_i[1:0];
        case (grant_idx)
            2'd1: begin
                sel_cmd = req_cmd_i[11:6];
                sel_arg = req_arg_i[63:32];
                sel_rsp = req_rsp_type_i[3:2];
            end
            2'd2: begin
                sel_cmd = req_cmd_i[17:12];
                sel_arg = req_arg_i[95:64];
                sel_rsp = req_rsp_type_i[5:4];
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_oh = 3'b000;
        case (owner_o)
            2'd0:    owner_oh = 3'b001;
            2'd1:    owner_oh = 3'b010;
            2'd2:    owner_oh = 3'b100;
            default: owner_oh = 3'b000;
        endcase
    end

    // Watchdog fires on the pulse that brings the count to the limit.
    assign active    = (state == S_ISSUE) || (state == S_WAIT);
    assign wd_inc    = {1'b0, wd_cnt} + (WW+1)'(1);
    assign wd_expire = active && (({1'b0, wd_cnt} >= WD_LIMIT) ||
                                  (clk_en_p_i && (wd_inc >= WD_LIMIT)));

    assign rsp_done  = (rsp_type_o == 2'd0) ? cmd_done_i : cmd_result_valid_i;
    assign complete  = (state == S_WAIT) && (timeout_i || rsp_done);
    assign cpl_err   = timeout_i | (cmd_result_valid_i & cmd_error_i);
    assign err_event = (complete && cpl_err) || (wd_expire && !complete);

    assign cmd_valid_o = (state == S_ISSUE);
    assign busy_o      = (state != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            gap_cnt        <= '0;
            wd_cnt         <= '0;
            owner_o        <= 2'd3;
            cmd_o          <= '0;
            cmd_arg_o      <= '0;
            rsp_type_o     <= '0;
            result_valid_o <= '0;
            result_error_o <= 1'b0;
            wd_timeout_o   <= 1'b0;
            err_locked_o   <= 1'b0;
        end else begin
            result_valid_o <= '0;
            result_error_o <= 1'b0;
            wd_timeout_o   <= 1'b0;

            // A fresh error outranks a simultaneous clear.
            if (err_event)
                err_locked_o <= 1'b1;
            else if (clear_err_i)
                err_locked_o <= 1'b0;

            if (active && clk_en_p_i && ({1'b0, wd_cnt} < WD_LIMIT))
                wd_cnt <= wd_inc[WW-1:0];

            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state      <= S_ISSUE;
                        owner_o    <= grant_idx;
                        cmd_o      <= sel_cmd;
                        cmd_arg_o  <= sel_arg;
                        rsp_type_o <= sel_rsp;
                        wd_cnt     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (wd_expire) begin
                        state          <= S_GAP;
                        gap_cnt        <= GW'(GapCycles);
                        result_valid_o <= owner_oh;
                        result_error_o <= 1'b1;
                        wd_timeout_o   <= 1'b1;
                    end else if (cmd_ready_i) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (complete || wd_expire) begin
                        state          <= S_GAP;
                        gap_cnt        <= GW'(GapCycles);
                        result_valid_o <= owner_oh;
                        result_error_o <= complete ? cpl_err : 1'b1;
                        wd_timeout_o   <= !complete;
                    end
                end
                default: begin
                    if (gap_cnt == '0) begin
                        state   <= S_IDLE;
                        owner_o <= 2'd3;
                    end else if (clk_en_p_i) begin
                        gap_cnt <= gap_cnt - GW'(1);
                        if (gap_cnt == GW'(1)) begin
                            state   <= S_IDLE;
                            owner_o <= 2'd3;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: priority, completion types, error lock, watchdog, reset abort.
`timescale 1ns/1ps
module tb_sd_cmd_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_en_p_i = 1'b0;
    logic [2:0]  req_valid_i = '0;
    logic [17:0] req_cmd_i = '0;
    logic [95:0] req_arg_i = '0;
    logic [5:0]  req_rsp_type_i = '0;
    logic [2:0]  req_ready_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i = 1'b0;
    logic [5:0]  cmd_o;
    logic [31:0] cmd_arg_o;
    logic [1:0]  rsp_type_o;
    logic        cmd_done_i = 1'b0;
    logic        cmd_result_valid_i = 1'b0;
    logic        cmd_error_i = 1'b0;
    logic        timeout_i = 1'b0;
    logic [2:0]  result_valid_o;
    logic        result_error_o;
    logic        wd_timeout_o;
    logic        err_locked_o;
    logic        clear_err_i = 1'b0;
    logic        busy_o;
    logic [1:0]  owner_o;

    int n_cmp = 0;
    int n_err = 0;

    sd_cmd_arbiter #(.GapCycles(8), .WatchdogCycles(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_en_p_i(clk_en_p_i),
        .req_valid_i(req_valid_i), .req_cmd_i(req_cmd_i), .req_arg_i(req_arg_i),
        .req_rsp_type_i(req_rsp_type_i), .req_ready_o(req_ready_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_o(cmd_o), .cmd_arg_o(cmd_arg_o), .rsp_type_o(rsp_type_o),
        .cmd_done_i(cmd_done_i), .cmd_result_valid_i(cmd_result_valid_i),
        .cmd_error_i(cmd_error_i), .timeout_i(timeout_i),
        .result_valid_o(result_valid_o), .result_error_o(result_error_o),
        .wd_timeout_o(wd_timeout_o), .err_locked_o(err_locked_o),
        .clear_err_i(clear_err_i), .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            clk_en_p_i = 1'b1;
            step();
            clk_en_p_i = 1'b0;
        end
    endtask

    task automatic set_req(input int idx, input logic [5:0] cmd,
                           input logic [31:0] arg, input logic [1:0] rsp);
        req_cmd_i[idx*6 +: 6]      = cmd;
        req_arg_i[idx*32 +: 32]    = arg;
        req_rsp_type_i[idx*2 +: 2] = rsp;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_owner", owner_o, 2'd3);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_cmd_valid", cmd_valid_o, 1'b0);
        chk("rst_lock", err_locked_o, 1'b0);
        chk("rst_result", result_valid_o, 3'b000);
        rst_i = 1'b0;
        step();

        // CMD12 and driver together: CMD12 wins
        set_req(0, 6'd12, 32'h0, 2'd3);
        set_req(2, 6'd0, 32'hCAFE_0001, 2'd0);
        req_valid_i = 3'b101;
        #1;
        chk("prio_ready", req_ready_o, 3'b001);
        step();
        chk("prio_cmd", cmd_o, 6'd12);
        chk("prio_owner", owner_o, 2'd0);
        chk("prio_cmd_valid", cmd_valid_o, 1'b1);
        chk("prio_no_ready", req_ready_o, 3'b000);
        req_valid_i = 3'b100;
        cmd_ready_i = 1'b1;
        step();
        cmd_ready_i = 1'b0;
        chk("wait_cmd_valid", cmd_valid_o, 1'b0);
        cmd_result_valid_i = 1'b1;
        step();
        cmd_result_valid_i = 1'b0;
        chk("c12_result", result_valid_o, 3'b001);
        chk("c12_err", result_error_o, 1'b0);
        chk("c12_lock", err_locked_o, 1'b0);
        step();
        chk("c12_one_cycle", result_valid_o, 3'b000);
        pulses(7);
        chk("gap7_busy", busy_o, 1'b1);
        chk("gap7_no_ready", req_ready_o, 3'b000);
        pulses(1);
        chk("gap8_idle", busy_o, 1'b0);
        chk("gap8_owner", owner_o, 2'd3);
        #1;
        chk("drv_ready", req_ready_o, 3'b100);
        step();
        chk("drv_owner", owner_o, 2'd2);
        chk("drv_arg", cmd_arg_o, 32'hCAFE_0001);
        chk("drv_rsp", rsp_type_o, 2'd0);

        // Driver CMD0, no response: only cmd_done_i completes
        cmd_ready_i = 1'b1;
        step();
        cmd_ready_i = 1'b0;
        req_valid_i = 3'b000;
        cmd_result_valid_i = 1'b1;
        step();
        cmd_result_valid_i = 1'b0;
        chk("cmd0_rv_ignored", result_valid_o, 3'b000);
        chk("cmd0_still_busy", busy_o, 1'b1);
        cmd_done_i = 1'b1;
        step();
        cmd_done_i = 1'b0;
        chk("cmd0_result", result_valid_o, 3'b100);
        chk("cmd0_err", result_error_o, 1'b0);
        pulses(7);
        chk("cmd0_gap7_busy", busy_o, 1'b1);
        pulses(1);
        chk("cmd0_gap8_idle", busy_o, 1'b0);

        // CMD23 timeout: error lock holds off pending driver
        set_req(1, 6'd23, 32'h0000_0010, 2'd2);
        set_req(2, 6'd18, 32'h0000_BEEF, 2'd2);
        req_valid_i = 3'b010;
        #1;
        chk("c23_ready", req_ready_o, 3'b010);
        step();
        chk("c23_cmd", cmd_o, 6'd23);
        timeout_i = 1'b1;
        step();
        timeout_i = 1'b0;
        chk("issue_ignores_to", result_valid_o, 3'b000);
        chk("issue_holds_valid", cmd_valid_o, 1'b1);
        cmd_ready_i = 1'b1;
        step();
        cmd_ready_i = 1'b0;
        req_valid_i = 3'b100;
        timeout_i = 1'b1;
        step();
        timeout_i = 1'b0;
        chk("c23_result", result_valid_o, 3'b010);
        chk("c23_err", result_error_o, 1'b1);
        chk("c23_lock", err_locked_o, 1'b1);
        pulses(8);
        chk("lock_idle", busy_o, 1'b0);
        #1;
        chk("lock_no_grant", req_ready_o, 3'b000);
        step();
        chk("lock_still_idle", busy_o, 1'b0);
        clear_err_i = 1'b1;
        step();
        clear_err_i = 1'b0;
        chk("lock_cleared", err_locked_o, 1'b0);
        #1;
        chk("post_clear_ready", req_ready_o, 3'b100);
        step();
        chk("post_clear_cmd", cmd_o, 6'd18);
        req_valid_i = 3'b000;

        // Watchdog with cmd_ready_i held low
        pulses(15);
        chk("wd15_no_timeout", wd_timeout_o, 1'b0);
        chk("wd15_valid", cmd_valid_o, 1'b1);
        pulses(1);
        chk("wd_timeout", wd_timeout_o, 1'b1);
        chk("wd_result", result_valid_o, 3'b100);
        chk("wd_err", result_error_o, 1'b1);
        chk("wd_cmd_valid", cmd_valid_o, 1'b0);
        chk("wd_lock", err_locked_o, 1'b1);
        step();
        chk("wd_one_cycle", wd_timeout_o, 1'b0);
        pulses(8);
        clear_err_i = 1'b1;
        step();
        clear_err_i = 1'b0;

        // Completion and watchdog expiry in the same cycle: completion wins
        set_req(2, 6'd0, 32'h0, 2'd0);
        req_valid_i = 3'b100;
        step();
        req_valid_i = 3'b000;
        cmd_ready_i = 1'b1;
        step();
        cmd_ready_i = 1'b0;
        pulses(15);
        chk("tie_pending", result_valid_o, 3'b000);
        clk_en_p_i = 1'b1;
        cmd_done_i = 1'b1;
        step();
        clk_en_p_i = 1'b0;
        cmd_done_i = 1'b0;
        chk("tie_result", result_valid_o, 3'b100);
        chk("tie_err", result_error_o, 1'b0);
        chk("tie_no_wd", wd_timeout_o, 1'b0);
        chk("tie_no_lock", err_locked_o, 1'b0);
        pulses(8);

        // Reset during WAIT_RSP abandons the command
        req_valid_i = 3'b001;
        step();
        req_valid_i = 3'b000;
        cmd_ready_i = 1'b1;
        step();
        cmd_ready_i = 1'b0;
        chk("pre_rst_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        cmd_result_valid_i = 1'b1;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_owner", owner_o, 2'd3);
        step();
        chk("arst_no_result", result_valid_o, 3'b000);
        rst_i = 1'b0;
        cmd_result_valid_i = 1'b0;
        req_valid_i = 3'b100;
        #1;
        chk("post_rst_ready", req_ready_o, 3'b100);
        step();
        chk("post_rst_owner", owner_o, 2'd2);
        req_valid_i = 3'b000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 SHALL have parameter GapCycles, default 8, meaning the number of clk_en_p_i pulses the CMD line stays idle after each completion (Ncc).
REQ-002 SHALL have parameter WatchdogCycles, default 1024, meaning the clk_en_p_i pulses allowed from grant to completion before a forced abort.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 clk_en_p_i  in  1  one-cycle pulse before each sd_clk posedge; paces gap and watchdog counters.
REQ-006 req_valid_i  in  3  per-requester request; bit0 auto CMD12, bit1 auto CMD23, bit2 driver.
REQ-007 req_cmd_i  in  3x6  command index per requester (requester n at bits 6n+5:6n).
REQ-008 req_arg_i  in  3x32  argument per requester.
REQ-009 req_rsp_type_i  in  3x2  response type per requester; 0 = no response, 1 = 136-bit, 2 = 48-bit, 3 = 48-bit busy.
REQ-010 req_ready_o  out  3  one-hot accept pulse to the granted requester.
REQ-011 cmd_valid_o / cmd_ready_i  out / in  1 / 1  command handshake to cmd_logic.
REQ-012 cmd_o, cmd_arg_o, rsp_type_o  out  6, 32, 2  latched command fields.
REQ-013 cmd_done_i, cmd_result_valid_i, cmd_error_i, timeout_i  in  1 each  completion events from cmd_logic; cmd_error_i qualified by cmd_result_valid_i.
REQ-014 result_valid_o  out  3  one-hot completion pulse routed to the owner.
REQ-015 result_error_o  out  1  error flag, valid with result_valid_o.
REQ-016 wd_timeout_o  out  1  one-cycle pulse on watchdog expiry.
REQ-017 err_locked_o / clear_err_i  out / in  1 / 1  error lock status and clear.
REQ-018 busy_o, owner_o  out  1, 2  busy = state not IDLE; owner = granted requester index (3 = none).

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT_RSP, GAP.
REQ-020 IDLE: when err_locked_o=0 and any req_valid_i is high, grant the lowest set index (fixed priority CMD12 > CMD23 > driver); pulse req_ready_o[owner] in that cycle, latch that requester's cmd, arg, and rsp_type into the output registers, and go to ISSUE next cycle.
REQ-021 ISSUE: hold cmd_valid_o=1 with stable fields; on cmd_valid_o&cmd_ready_i go to WAIT_RSP; completion inputs ignored in ISSUE.
REQ-022 WAIT_RSP completion: rsp_type 0 -> cmd_done_i; else cmd_result_valid_i; timeout_i completes any type with error.
REQ-023 On completion pulse result_valid_o[owner] for exactly one cycle; result_error_o = timeout_i | (cmd_result_valid_i & cmd_error_i); go to GAP.
REQ-024 An errored completion SHALL set err_locked_o; no grants while locked; clear_err_i clears lock next cycle; clear and new error in the same cycle leaves the lock set.
REQ-025 GAP: load counter with GapCycles, decrement on each clk_en_p_i, return to IDLE when it reaches 0; GapCycles=0 -> GAP lasts one clk_i cycle.
REQ-026 Watchdog SHALL count clk_en_p_i in ISSUE and WAIT_RSP, reset at grant; at WatchdogCycles: pulse wd_timeout_o, result_valid_o[owner] with result_error_o=1, deassert cmd_valid_o, set lock, go to GAP.
REQ-027 Completion and watchdog expiry in the same cycle: completion wins, no wd_timeout_o.
REQ-028 No preemption: a higher-priority request arriving after grant waits until IDLE.
REQ-029 A requester dropping req_valid_i after accept SHALL NOT affect the in-flight command.
REQ-030 Counters SHALL saturate, never wrap; widths $clog2(param+1).

Reset
REQ-031 On rst_i: state IDLE, all outputs 0 except owner_o=3, counters 0, lock clear; asserting mid-command abandons it with no result pulse.

Verification
REQ-032 CMD12 and driver valid same cycle in IDLE -> req_ready_o=3'b001, cmd_o=12; driver granted only after GAP of 8 clk_en_p_i pulses.
REQ-033 Driver CMD0 rsp_type 0, cmd_done_i -> result_valid_o=3'b100, result_error_o=0, busy_o low 8 pulses later.
REQ-034 CMD23 rsp_type 2, timeout_i in WAIT_RSP -> result_valid_o=3'b010, result_error_o=1, err_locked_o=1; pending driver not granted until clear_err_i.
REQ-035 cmd_ready_i held low, WatchdogCycles=16 -> wd_timeout_o pulse after 16th clk_en_p_i, cmd_valid_o=0, lock set.
REQ-036 rst_i asserted in WAIT_RSP -> immediate IDLE, owner_o=3, no result_valid_o pulse; new request granted after release.
